pipe_ctrl_n: RTL and testbench
==============================

# pipe_ctrl_n

Parametrised pipeline control unit for the MIPS32 core: generates per-stage stall vectors from an arbitrary number of stage stall requests and sequences exception flush and PC redirect through a small state machine. Sits beside the pipeline, taking stall requests from every stage and the exception code and EPC from MEM. Drives the stage registers (stall, flush) and the PC register (new_pc, pc_load). Unlike the previous single-cycle combinational controller, flush is registered and held for a configurable number of cycles, and all nonzero exception codes redirect.

## Interface
Parameters:
- STAGES, 6, number of stall-controlled stages; index 0 = PC, STAGES-1 = WB
- FLUSH_CYCLES, 1, cycles flush is held per exception (≥1)
- EXC_VECTOR, 32'hBFC0_0380, general exception entry address
- WDOG_LIMIT, 1024, consecutive stall cycles before watchdog trips (watchdog build only)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- stallreq_i  in  STAGES  bit k = stage k requests stall
- excepttype_i  in  32  exception code from MEM; 0 = none
- cp0_epc_i  in  32  EPC from CP0
- stall_o  out  STAGES  bit i = hold stage i register
- flush_o  out  1  clear all stage registers
- new_pc_o  out  32  redirect target
- pc_load_o  out  1  one-cycle strobe: PC loads new_pc_o
- busy_o  out  1  controller in FLUSH state
- exc_count_o  out  16  saturating count of accepted exceptions
- wdog_timeout_o  out  1  sticky watchdog flag (tied 0 without watchdog)

## Operation
- States: IDLE, FLUSH. Reset → IDLE.
- IDLE, excepttype_i == 0: k = highest set index of stallreq_i; stall_o[i] = 1 for all i ≤ k, 0 above; no request → all 0. Combinational.
- IDLE, excepttype_i != 0: exception accepted; stall_o = 0 that cycle; stall requests ignored. At next edge: state → FLUSH, flush counter = FLUSH_CYCLES-1, new_pc_o registered, pc_load_o = 1, exc_count_o += 1 (saturates at 16'hFFFF).
- Target: code 32'h0000_000E (eret) → cp0_epc_i sampled at acceptance; every other nonzero code (1, 8, 9, A, C, D and any unlisted) → EXC_VECTOR.
- FLUSH: flush_o = 1, busy_o = 1, stall_o = 0, new_pc_o held, excepttype_i ignored. Counter decrements each cycle; at 0 → IDLE next edge.
- pc_load_o high only in first FLUSH cycle.
- exc_count_o and new_pc_o hold values in IDLE.

## Timing
- Reset (asynchronous assert, synchronous release): stall_o 0, flush_o 0, new_pc_o 0, pc_load_o 0, busy_o 0, exc_count_o 0, wdog_timeout_o 0, state IDLE. Reset mid-FLUSH aborts immediately.
- Stall: 0-cycle latency.
- Exception at cycle T → flush_o/pc_load_o/new_pc_o valid T+1; flush_o high T+1..T+FLUSH_CYCLES; IDLE at T+FLUSH_CYCLES+1, where a new exception may be accepted in that same cycle.
- Exception held asserted across FLUSH: re-accepted on the first IDLE cycle (MEM must clear it via flush).
- Simultaneous exception and stall request: exception wins.

## Configuration
- PIPE_CTRL_WATCHDOG_EN defined: 16-bit counter increments each cycle stall_o != 0, clears on any cycle with stall_o == 0 or in FLUSH. Reaching WDOG_LIMIT sets wdog_timeout_o (sticky until reset); counter saturates.
- Undefined: no counter; wdog_timeout_o constant 0; WDOG_LIMIT unused.

## Structure
- Shared package/defines: exception code constants (EXC_INT 1, EXC_SYSCALL 8, EXC_BREAK 9, EXC_RI A, EXC_OV C, EXC_TRAP D, EXC_ERET E), default EXC_VECTOR, state encoding.
- One sub-module: stall_mask_gen (priority encoder, STAGES-wide request → thermometer stall mask).
- FSM, flush counter, exception counter, and watchdog in top level.

## Test plan
- STAGES=6, stallreq_i=6'b010000, no exception → stall_o=6'b011111, flush_o=0 same cycle.
- stallreq_i=6'b000101 → stall_o=6'b000111; then 0 → stall_o=0.
- FLUSH_CYCLES=3, excepttype_i=8 for one cycle at T with stallreq_i=6'b001000 → stall_o=0 at T; flush_o high T+1..T+3; pc_load_o only T+1; new_pc_o=32'hBFC0_0380; exc_count_o=1.
- excepttype_i=E, cp0_epc_i=32'h8000_1234 → new_pc_o=32'h8000_1234; unlisted code 32'h0000_0004 → new_pc_o=EXC_VECTOR.
- Second exception during FLUSH → ignored; exc_count_o unchanged; assert rst mid-FLUSH → all outputs 0 immediately.
- With PIPE_CTRL_WATCHDOG_EN, WDOG_LIMIT=8, stallreq_i held nonzero 8 cycles → wdog_timeout_o=1, stays 1 after stall clears; one non-stall cycle at cycle 7 → no trip.

Source files
------------

// File: rtl/pipe_ctrl_n_pkg.sv
// Shared definitions for the pipeline control unit: exception codes,
// default exception vector, controller state encoding and the redirect
// target selection helper.
package pipe_ctrl_n_pkg;

    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_BREAK   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI      = 32'h0000_000A;
    localparam logic [31:0] EXC_OV      = 32'h0000_000C;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000D;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000E;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } ctrl_state_e;

    // eret returns to the saved EPC; every other nonzero code enters the
    // general exception vector.
    function automatic logic [31:0] redirect_target(
        input logic [31:0] code,
        input logic [31:0] epc,
        input logic [31:0] vector
    );
        logic [31:0] target_s;
        case (code)
            EXC_ERET: target_s = epc;
            default:  target_s = vector;
        endcase
        return target_s;
    endfunction

endpackage

// File: rtl/pipe_ctrl_n_stall_mask_gen.sv
// Priority encoder producing a thermometer stall mask: the highest
// requesting stage and every stage below it (towards PC) are held.
module stall_mask_gen #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] mask
);

    logic [WIDTH-1:0] mask_s;
    logic             acc_s;

    // Walk from the top stage down, OR-accumulating requests into the mask.
    always_comb begin
        mask_s = {WIDTH{1'b0}};
        acc_s  = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc_s     = acc_s | req[i];
            mask_s[i] = acc_s;
        end
    end

    assign mask = mask_s;

endmodule

// File: rtl/pipe_ctrl_n.sv
// Pipeline control unit: thermometer stall generation from per-stage
// requests, and an IDLE/FLUSH sequencer that redirects the PC and holds
// flush for FLUSH_CYCLES cycles on every accepted exception.
// Optional build macro PIPE_CTRL_WATCHDOG_EN adds a stall watchdog that
// raises a sticky wdog_timeout_o after WDOG_LIMIT consecutive stall cycles.
module pipe_ctrl_n
    import pipe_ctrl_n_pkg::*;
#(
    parameter int          STAGES       = 6,
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int          WDOG_LIMIT   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq_i,
    input  logic [31:0]       excepttype_i,
    input  logic [31:0]       cp0_epc_i,
    output logic [STAGES-1:0] stall_o,
    output logic              flush_o,
    output logic [31:0]       new_pc_o,
    output logic              pc_load_o,
    output logic              busy_o,
    output logic [15:0]       exc_count_o,
    output logic              wdog_timeout_o
);

    localparam int              CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Reject configurations the sequencer and watchdog cannot represent.
    if (FLUSH_CYCLES < 1 || WDOG_LIMIT < 1 || WDOG_LIMIT > 65535) begin : g_param_check
        $error("pipe_ctrl_n: FLUSH_CYCLES must be >= 1 and WDOG_LIMIT in 1..65535");
    end

    ctrl_state_e       state_r;
    ctrl_state_e       state_next_s;
    logic [CNT_W-1:0]  flush_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_next_s;
    logic              accept_s;
    logic [STAGES-1:0] mask_s;
    logic [STAGES-1:0] stall_s;
    logic [31:0]       new_pc_r;
    logic              pc_load_r;
    logic [15:0]       exc_count_r;

    stall_mask_gen #(
        .WIDTH (STAGES)
    ) u_stall_mask_gen (
        .req  (stallreq_i),
        .mask (mask_s)
    );

    // State and flush counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            flush_cnt_r <= CNT_ZERO;
        end else begin
            state_r     <= state_next_s;
            flush_cnt_r <= flush_cnt_next_s;
        end
    end

    // Next-state logic: accept exceptions in IDLE, count flush cycles down.
    always_comb begin
        state_next_s     = state_r;
        flush_cnt_next_s = flush_cnt_r;
        accept_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (excepttype_i != EXC_NONE) begin
                    accept_s         = 1'b1;
                    state_next_s     = ST_FLUSH;
                    flush_cnt_next_s = CNT_INIT;
                end else begin
                    state_next_s     = ST_IDLE;
                    flush_cnt_next_s = flush_cnt_r;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == CNT_ZERO) begin
                    state_next_s     = ST_IDLE;
                    flush_cnt_next_s = CNT_ZERO;
                end else begin
                    state_next_s     = ST_FLUSH;
                    flush_cnt_next_s = flush_cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_next_s     = ST_IDLE;
                flush_cnt_next_s = CNT_ZERO;
            end
        endcase
    end

    // Stall mask applies only in IDLE without a pending exception; the
    // exception wins over any simultaneous stall request.
    always_comb begin
        stall_s = {STAGES{1'b0}};
        if (rst && (state_r == ST_IDLE) && (excepttype_i == EXC_NONE)) begin
            stall_s = mask_s;
        end else begin
            stall_s = {STAGES{1'b0}};
        end
    end

    // Redirect target, PC-load strobe and saturating exception counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            new_pc_r    <= 32'h0000_0000;
            pc_load_r   <= 1'b0;
            exc_count_r <= 16'h0000;
        end else begin
            pc_load_r <= accept_s;
            if (accept_s) begin
                new_pc_r <= redirect_target(excepttype_i, cp0_epc_i, EXC_VECTOR);
                if (exc_count_r != 16'hFFFF) begin
                    exc_count_r <= exc_count_r + 16'h0001;
                end else begin
                    exc_count_r <= exc_count_r;
                end
            end else begin
                new_pc_r    <= new_pc_r;
                exc_count_r <= exc_count_r;
            end
        end
    end

`ifdef PIPE_CTRL_WATCHDOG_EN
    localparam logic [16:0] WDOG_LIMIT_W = 17'(WDOG_LIMIT);

    logic [15:0] wdog_cnt_r;
    logic        wdog_timeout_r;
    logic        stalling_s;

    assign stalling_s = (state_r == ST_IDLE) && (stall_s != {STAGES{1'b0}});

    // Consecutive-stall counter with a sticky trip flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_cnt_r     <= 16'h0000;
            wdog_timeout_r <= 1'b0;
        end else begin
            if (!stalling_s) begin
                wdog_cnt_r <= 16'h0000;
            end else if (wdog_cnt_r != 16'hFFFF) begin
                wdog_cnt_r <= wdog_cnt_r + 16'h0001;
            end else begin
                wdog_cnt_r <= wdog_cnt_r;
            end
            if (stalling_s && (({1'b0, wdog_cnt_r} + 17'h0_0001) >= WDOG_LIMIT_W)) begin
                wdog_timeout_r <= 1'b1;
            end else begin
                wdog_timeout_r <= wdog_timeout_r;
            end
        end
    end

    assign wdog_timeout_o = wdog_timeout_r;
`else
    assign wdog_timeout_o = 1'b0;
`endif

    assign stall_o     = stall_s;
    assign flush_o     = (state_r == ST_FLUSH);
    assign busy_o      = (state_r == ST_FLUSH);
    assign new_pc_o    = new_pc_r;
    assign pc_load_o   = pc_load_r;
    assign exc_count_o = exc_count_r;

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Self-checking bench for pipe_ctrl_n (STAGES=6, FLUSH_CYCLES=3,
// WDOG_LIMIT=8). Redirect expectations go into a scoreboard queue when an
// exception is driven and are popped when pc_load_o is seen.
module tb_pipe_ctrl_n;

    localparam int          STAGES       = 6;
    localparam int          FLUSH_CYCLES = 3;
    localparam int          WDOG_LIMIT   = 8;
    localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
`ifdef PIPE_CTRL_WATCHDOG_EN
    localparam logic        WD_EN = 1'b1;
`else
    localparam logic        WD_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [15:0] cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [STAGES-1:0] stallreq_i;
    logic [31:0]       excepttype_i;
    logic [31:0]       cp0_epc_i;
    logic [STAGES-1:0] stall_o;
    logic              flush_o;
    logic [31:0]       new_pc_o;
    logic              pc_load_o;
    logic              busy_o;
    logic [15:0]       exc_count_o;
    logic              wdog_timeout_o;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb_q[$];
    logic [15:0] model_cnt = 16'h0000;

    pipe_ctrl_n #(
        .STAGES       (STAGES),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .EXC_VECTOR   (EXC_VECTOR),
        .WDOG_LIMIT   (WDOG_LIMIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_i     (stallreq_i),
        .excepttype_i   (excepttype_i),
        .cp0_epc_i      (cp0_epc_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .new_pc_o       (new_pc_o),
        .pc_load_o      (pc_load_o),
        .busy_o         (busy_o),
        .exc_count_o    (exc_count_o),
        .wdog_timeout_o (wdog_timeout_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: every PC-load strobe must match the oldest expected redirect.
    always @(negedge clk) begin
        if (rst === 1'b1 && pc_load_o === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_load: got pc_load with new_pc=%h, none expected", new_pc_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (new_pc_o !== e.pc || exc_count_o !== e.cnt) begin
                    errors++;
                    $display("FAIL sb_redirect: got pc=%h cnt=%0d expected pc=%h cnt=%0d",
                             new_pc_o, exc_count_o, e.pc, e.cnt);
                end
            end
        end
    end

    task automatic test_reset();
        #12;
        checks++;
        if (stall_o !== 6'b000000 || flush_o !== 1'b0 || new_pc_o !== 32'h0 || pc_load_o !== 1'b0 ||
            busy_o !== 1'b0 || exc_count_o !== 16'h0 || wdog_timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got stall=%b flush=%b pc=%h load=%b busy=%b cnt=%0d wd=%b expected all 0",
                     stall_o, flush_o, new_pc_o, pc_load_o, busy_o, exc_count_o, wdog_timeout_o);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_stall();
        logic [STAGES-1:0] req_tab [6];
        logic [STAGES-1:0] exp_tab [6];
        req_tab = '{6'b010000, 6'b000101, 6'b000000, 6'b100000, 6'b000001, 6'b111111};
        exp_tab = '{6'b011111, 6'b000111, 6'b000000, 6'b111111, 6'b000001, 6'b111111};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            stallreq_i = req_tab[i];
            #2;
            checks++;
            if (stall_o !== exp_tab[i] || flush_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_mask[%0d]: req=%b got stall=%b flush=%b expected stall=%b flush=0",
                         i, req_tab[i], stall_o, flush_o, exp_tab[i]);
            end
        end
        @(negedge clk);
        stallreq_i = 6'b000000;
    endtask

    task automatic test_exception(input logic [31:0] code, input logic [31:0] epc,
                                  input logic [31:0] exp_pc, input string name);
        @(negedge clk);
        excepttype_i = code;
        cp0_epc_i    = epc;
        stallreq_i   = 6'b001000;
        #2;
        checks++;
        if (stall_o !== 6'b000000 || flush_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept: got stall=%b flush=%b expected stall=000000 flush=0", name, stall_o, flush_o);
        end
        model_cnt = (model_cnt == 16'hFFFF) ? model_cnt : model_cnt + 16'h0001;
        sb_q.push_back('{exp_pc, model_cnt});
        for (int c = 1; c <= FLUSH_CYCLES; c++) begin
            @(negedge clk);
            excepttype_i = 32'h0;
            cp0_epc_i    = 32'hDEAD_0000;
            stallreq_i   = 6'b000011;
            #2;
            checks++;
            if (flush_o !== 1'b1 || busy_o !== 1'b1 || stall_o !== 6'b000000 ||
                pc_load_o !== (c == 1) || new_pc_o !== exp_pc) begin
                errors++;
                $display("FAIL %s_flush[%0d]: got flush=%b busy=%b stall=%b load=%b pc=%h expected 1 1 000000 %b %h",
                         name, c, flush_o, busy_o, stall_o, pc_load_o, new_pc_o, (c == 1), exp_pc);
            end
        end
        @(negedge clk);
        #2;
        checks++;
        if (flush_o !== 1'b0 || busy_o !== 1'b0 || pc_load_o !== 1'b0 || new_pc_o !== exp_pc ||
            exc_count_o !== model_cnt || stall_o !== 6'b000011) begin
            errors++;
            $display("FAIL %s_idle: got flush=%b busy=%b load=%b pc=%h cnt=%0d stall=%b expected 0 0 0 %h %0d 000011",
                     name, flush_o, busy_o, pc_load_o, new_pc_o, exc_count_o, stall_o, exp_pc, model_cnt);
        end
        stallreq_i = 6'b000000;
    endtask

    task automatic test_ignore_during_flush();
        @(negedge clk);
        excepttype_i = 32'h0000_0001;
        model_cnt    = model_cnt + 16'h0001;
        sb_q.push_back('{EXC_VECTOR, model_cnt});
        @(negedge clk);
        excepttype_i = 32'h0;
        @(negedge clk);
        excepttype_i = 32'h0000_0009;
        stallreq_i   = 6'b000100;
        #2;
        checks++;
        if (flush_o !== 1'b1 || stall_o !== 6'b000000) begin
            errors++;
            $display("FAIL ignore_in_flush: got flush=%b stall=%b expected 1 000000", flush_o, stall_o);
        end
        @(negedge clk);
        excepttype_i = 32'h0;
        stallreq_i   = 6'b000000;
        @(negedge clk);
        #2;
        checks++;
        if (flush_o !== 1'b0 || exc_count_o !== model_cnt || new_pc_o !== EXC_VECTOR) begin
            errors++;
            $display("FAIL ignore_count: got flush=%b cnt=%0d pc=%h expected 0 %0d %h",
                     flush_o, exc_count_o, new_pc_o, model_cnt, EXC_VECTOR);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        excepttype_i = 32'h0000_000C;
        model_cnt    = model_cnt + 16'h0001;
        sb_q.push_back('{EXC_VECTOR, model_cnt});
        for (int c = 1; c <= FLUSH_CYCLES; c++) begin
            @(negedge clk);
        end
        @(negedge clk);
        stallreq_i = 6'b000100;
        #2;
        checks++;
        if (flush_o !== 1'b0 || busy_o !== 1'b0 || stall_o !== 6'b000000) begin
            errors++;
            $display("FAIL b2b_idle_gap: got flush=%b busy=%b stall=%b expected 0 0 000000", flush_o, busy_o, stall_o);
        end
        model_cnt = model_cnt + 16'h0001;
        sb_q.push_back('{EXC_VECTOR, model_cnt});
        @(negedge clk);
        excepttype_i = 32'h0;
        stallreq_i   = 6'b000000;
        #2;
        checks++;
        if (flush_o !== 1'b1 || pc_load_o !== 1'b1 || exc_count_o !== model_cnt) begin
            errors++;
            $display("FAIL b2b_reaccept: got flush=%b load=%b cnt=%0d expected 1 1 %0d",
                     flush_o, pc_load_o, exc_count_o, model_cnt);
        end
        for (int c = 2; c <= FLUSH_CYCLES + 1; c++) begin
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_flush();
        @(negedge clk);
        excepttype_i = 32'h0000_000D;
        model_cnt    = model_cnt + 16'h0001;
        sb_q.push_back('{EXC_VECTOR, model_cnt});
        @(negedge clk);
        excepttype_i = 32'h0;
        @(negedge clk);
        stallreq_i = 6'b000111;
        #2;
        checks++;
        if (flush_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_flush: got flush=%b expected 1", flush_o);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (stall_o !== 6'b000000 || flush_o !== 1'b0 || new_pc_o !== 32'h0 || pc_load_o !== 1'b0 ||
            busy_o !== 1'b0 || exc_count_o !== 16'h0 || wdog_timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_flush: got stall=%b flush=%b pc=%h load=%b busy=%b cnt=%0d wd=%b expected all 0",
                     stall_o, flush_o, new_pc_o, pc_load_o, busy_o, exc_count_o, wdog_timeout_o);
        end
        model_cnt = 16'h0000;
        @(negedge clk);
        rst        = 1'b1;
        stallreq_i = 6'b000000;
        @(negedge clk);
        #2;
        checks++;
        if (flush_o !== 1'b0 || busy_o !== 1'b0 || exc_count_o !== 16'h0) begin
            errors++;
            $display("FAIL rst_release: got flush=%b busy=%b cnt=%0d expected 0 0 0", flush_o, busy_o, exc_count_o);
        end
    endtask

    task automatic test_watchdog();
        // Seven stall cycles, a gap at cycle 7, then seven more: never trips.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            stallreq_i = 6'b000010;
        end
        @(negedge clk);
        stallreq_i = 6'b000000;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            stallreq_i = 6'b000010;
        end
        @(negedge clk);
        stallreq_i = 6'b000000;
        #2;
        checks++;
        if (wdog_timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL wdog_gap: got %b expected 0", wdog_timeout_o);
        end
        // WDOG_LIMIT consecutive stall cycles trip the watchdog (if built in).
        for (int i = 0; i < WDOG_LIMIT; i++) begin
            @(negedge clk);
            stallreq_i = 6'b100000;
        end
        @(negedge clk);
        stallreq_i = 6'b000000;
        #2;
        checks++;
        if (wdog_timeout_o !== WD_EN) begin
            errors++;
            $display("FAIL wdog_trip: got %b expected %b", wdog_timeout_o, WD_EN);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
        end
        #2;
        checks++;
        if (wdog_timeout_o !== WD_EN) begin
            errors++;
            $display("FAIL wdog_sticky: got %b expected %b", wdog_timeout_o, WD_EN);
        end
    endtask

    initial begin
        rst          = 1'b0;
        stallreq_i   = 6'b000000;
        excepttype_i = 32'h0;
        cp0_epc_i    = 32'h0;
        test_reset();
        test_stall();
        test_exception(32'h0000_0008, 32'h0000_0000, EXC_VECTOR, "syscall");
        test_exception(32'h0000_000E, 32'h8000_1234, 32'h8000_1234, "eret");
        test_exception(32'h0000_0004, 32'h8000_1234, EXC_VECTOR, "unlisted");
        test_ignore_during_flush();
        test_back_to_back();
        test_reset_mid_flush();
        test_watchdog();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d redirects never loaded expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within limit");
        $fatal(1, "timeout");
    end

endmodule
